// File: rtl/stopwatch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | stopwatch_pkg : digit-select encodings, frame struct and seven-seg glyphs  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package stopwatch_pkg;

  typedef enum logic [1:0] {
    SEL_SEC_ONES = 2'b00,
    SEL_SEC_TENS = 2'b01,
    SEL_MIN_ONES = 2'b10,
    SEL_MIN_TENS = 2'b11
  } digit_sel_e;

  typedef struct packed {
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
  } frame_t;

  // Active-high glyphs, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

endpackage
`default_nettype wire

// File: rtl/bcd_to_seg7.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bcd_to_seg7 : combinational BCD to active-high glyph, dash above 9         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module bcd_to_seg7
  import stopwatch_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/stopwatch_seg_display.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | stopwatch_seg_display : 4-digit MM:SS multiplexed seven-segment driver     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module stopwatch_seg_display
  import stopwatch_pkg::*;
#(
  parameter int unsigned SCAN_DIV   = 100_000,
  parameter int unsigned BLINK_DIV  = 25_000_000,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic       clk_c,
  input  logic       reset_c,
  input  logic       adj,
  input  logic [1:0] sel,
  input  logic [3:0] sec_ones,
  input  logic [3:0] sec_tens,
  input  logic [3:0] min_ones,
  input  logic [3:0] min_tens,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an
);

  localparam int unsigned SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
  localparam logic [6:0] SEG_POL = {7{ACTIVE_LOW}};
  localparam logic [3:0] AN_POL  = {4{ACTIVE_LOW}};

  logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_phase_q, blink_phase_d;
  logic [1:0]         idx_q, idx_d;
  frame_t             frame_q, frame_d;
  logic [6:0]         seg_q, seg_d;
  logic               dp_q, dp_d;
  logic [3:0]         an_q, an_d;

  logic       scan_tick;
  logic       slot_start;
  logic       blink_off;
  logic [3:0] cur_bcd;
  logic [6:0] cur_glyph;

  assign scan_tick  = (scan_cnt_q == SCAN_LAST);
  // The cycle after scan_tick is the blank cycle; outputs for the new slot load at its end
  assign slot_start = (scan_cnt_q == '0);
  assign blink_off  = adj && blink_phase_q && (idx_q == sel);

  always_comb begin
    scan_cnt_d = scan_tick ? '0 : scan_cnt_q + SCAN_W'(1);
    idx_d      = scan_tick ? idx_q + 2'd1 : idx_q;
    frame_d    = frame_q;
    if (scan_tick && (idx_q == SEL_MIN_TENS)) begin
      frame_d = '{min_tens: min_tens, min_ones: min_ones,
                  sec_tens: sec_tens, sec_ones: sec_ones};
    end
  end

  always_comb begin
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (!adj) begin
      blink_cnt_d   = '0;
      blink_phase_d = 1'b0;
    end else if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d   = '0;
      blink_phase_d = ~blink_phase_q;
    end else begin
      blink_cnt_d = blink_cnt_q + BLINK_W'(1);
    end
  end

  always_comb begin
    cur_bcd = frame_q.sec_ones;
    case (idx_q)
      SEL_SEC_ONES: cur_bcd = frame_q.sec_ones;
      SEL_SEC_TENS: cur_bcd = frame_q.sec_tens;
      SEL_MIN_ONES: cur_bcd = frame_q.min_ones;
      SEL_MIN_TENS: cur_bcd = frame_q.min_tens;
      default:      cur_bcd = frame_q.sec_ones;
    endcase
  end

  bcd_to_seg7 u_dec (
    .bcd_i (cur_bcd),
    .seg_o (cur_glyph)
  );

  // Output regs hold the pin-polarity value, so the XOR is the only inversion point
  always_comb begin
    an_d  = an_q;
    seg_d = seg_q;
    dp_d  = dp_q;
    if (scan_tick) begin
      an_d  = AN_POL;
      seg_d = SEG_OFF ^ SEG_POL;
      dp_d  = ACTIVE_LOW;
    end else if (slot_start) begin
      an_d  = (blink_off ? 4'b0000 : (4'b0001 << idx_q)) ^ AN_POL;
      seg_d = cur_glyph ^ SEG_POL;
      dp_d  = (idx_q == SEL_MIN_ONES) ^ ACTIVE_LOW;
    end
  end

  always_ff @(posedge clk_c or posedge reset_c) begin
    if (reset_c) begin
      scan_cnt_q    <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      idx_q         <= 2'd0;
      frame_q       <= '0;
      an_q          <= AN_POL;
      seg_q         <= SEG_OFF ^ SEG_POL;
      dp_q          <= ACTIVE_LOW;
    end else begin
      scan_cnt_q    <= scan_cnt_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      idx_q         <= idx_d;
      frame_q       <= frame_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule
`default_nettype wire
